// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: opcode-type bit positions, funct3 access codes, FSM states.
// Opcode type is one-hot; the OPC_* constants are bit indices into that vector.
package mem_pkg;

  localparam int OPCODE_WIDTH = 11;

  localparam int OPC_LUI    = 0;
  localparam int OPC_AUIPC  = 1;
  localparam int OPC_JAL    = 2;
  localparam int OPC_JALR   = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_LOAD   = 5;
  localparam int OPC_STORE  = 6;
  localparam int OPC_OP_IMM = 7;
  localparam int OPC_OP     = 8;
  localparam int OPC_FENCE  = 9;
  localparam int OPC_SYSTEM = 10;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store data replication / byte enables, load lane select and extension,
// and misalignment detection from the low address bits and access size.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_load_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_wdata   = i_rs2;
    o_byte_en = 4'b1111;
    case (i_funct3)
      FUNCT3_B: begin
        o_wdata   = {4{i_rs2[7:0]}};
        o_byte_en = 4'b0001 << i_addr;
      end
      FUNCT3_H: begin
        o_wdata   = {2{i_rs2[15:0]}};
        o_byte_en = 4'b0011 << i_addr;
      end
      default: ;
    endcase
  end

  // Reserved funct3 codes behave as a full word for both extension and alignment.
  always_comb begin
    o_load_data  = i_rdata;
    o_misaligned = (i_addr != 2'd0);
    case (i_funct3)
      FUNCT3_B: begin
        o_load_data  = {{24{w_byte[7]}}, w_byte};
        o_misaligned = 1'b0;
      end
      FUNCT3_BU: begin
        o_load_data  = {24'd0, w_byte};
        o_misaligned = 1'b0;
      end
      FUNCT3_H: begin
        o_load_data  = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr[0];
      end
      FUNCT3_HU: begin
        o_load_data  = {16'd0, w_half};
        o_misaligned = i_addr[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: non-memory ops and misaligned accesses retire 1 cycle after capture,
// aligned loads/stores hold in ACCESS (stalling upstream) until dmem_ack, retiring the cycle after.
module memory_access
  import mem_pkg::*;
#(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    execute_clk_en,
  input  logic [OPCODE_WIDTH-1:0] execute_opcode_type,
  input  logic [2:0]              execute_funct3,
  input  logic [31:0]             execute_y,
  input  logic [31:0]             execute_rs2_data,
  input  logic                    execute_rd_wr_en,
  input  logic [4:0]              execute_rd,
  input  logic [31:0]             execute_pc,
  input  logic                    writeback_flush,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [DMEM_ADDR_W-1:0]  dmem_addr,
  output logic [31:0]             dmem_wdata,
  output logic [3:0]              dmem_byte_en,
  input  logic                    dmem_ack,
  input  logic [31:0]             dmem_rdata,
  output logic                    memory_clk_en,
  output logic [OPCODE_WIDTH-1:0] memory_opcode_type,
  output logic [2:0]              memory_funct3,
  output logic [31:0]             memory_data_load,
  output logic                    memory_rd_wr_en,
  output logic [4:0]              memory_rd,
  output logic [31:0]             memory_rd_wr_data,
  output logic [31:0]             memory_pc,
  output logic                    memory_load_misaligned,
  output logic                    memory_store_misaligned,
  output logic                    next_stall
);

  mem_state_t              r_state;
  mem_state_t              w_next_state;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [2:0]              r_funct3;
  logic [31:0]             r_y;
  logic [31:0]             r_rs2;
  logic [31:0]             r_pc;
  logic                    r_rd_wr_en;
  logic [4:0]              r_rd;
  logic                    r_req;
  logic                    r_flushed;
  logic                    r_clk_en;
  logic                    r_out_rd_wr_en;
  logic                    r_load_mis;
  logic                    r_store_mis;
  logic [31:0]             r_data_load;

  logic                    w_in_access;
  logic                    w_capture;
  logic                    w_exec_load;
  logic                    w_exec_store;
  logic                    w_go_access;
  logic                    w_retire_now;
  logic                    w_drop;
  logic [1:0]              w_al_addr;
  logic [2:0]              w_al_funct3;
  logic [31:0]             w_wdata;
  logic [3:0]              w_byte_en;
  logic [31:0]             w_load_data;
  logic                    w_misaligned;

  assign w_in_access  = (r_state == S_ACCESS);
  assign w_capture    = !w_in_access && execute_clk_en && !writeback_flush;
  assign w_exec_load  = execute_opcode_type[OPC_LOAD];
  assign w_exec_store = execute_opcode_type[OPC_STORE];
  assign w_go_access  = w_capture && (w_exec_load || w_exec_store) && !w_misaligned;
  assign w_retire_now = w_capture && !w_go_access;
  assign w_drop       = r_flushed || writeback_flush;

  // One aligner serves both phases: alignment check on execute inputs in IDLE, lanes from stage regs in ACCESS.
  assign w_al_addr   = w_in_access ? r_y[1:0] : execute_y[1:0];
  assign w_al_funct3 = w_in_access ? r_funct3 : execute_funct3;

  load_store_align u_align (
    .i_addr       (w_al_addr),
    .i_funct3     (w_al_funct3),
    .i_rs2        (r_rs2),
    .i_rdata      (dmem_rdata),
    .o_wdata      (w_wdata),
    .o_byte_en    (w_byte_en),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_go_access) w_next_state = S_ACCESS;
      S_ACCESS: if (dmem_ack)    w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    next_stall = w_in_access;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode       <= '0;
      r_funct3       <= '0;
      r_y            <= '0;
      r_rs2          <= '0;
      r_pc           <= '0;
      r_rd_wr_en     <= 1'b0;
      r_rd           <= '0;
      r_req          <= 1'b0;
      r_flushed      <= 1'b0;
      r_clk_en       <= 1'b0;
      r_out_rd_wr_en <= 1'b0;
      r_load_mis     <= 1'b0;
      r_store_mis    <= 1'b0;
      r_data_load    <= '0;
    end else begin
      r_clk_en    <= 1'b0;
      r_load_mis  <= 1'b0;
      r_store_mis <= 1'b0;
      if (w_capture) begin
        r_opcode   <= execute_opcode_type;
        r_funct3   <= execute_funct3;
        r_y        <= execute_y;
        r_rs2      <= execute_rs2_data;
        r_pc       <= execute_pc;
        r_rd_wr_en <= execute_rd_wr_en;
        r_rd       <= execute_rd;
      end
      if (w_go_access) r_req <= 1'b1;
      if (w_retire_now) begin
        r_clk_en       <= 1'b1;
        r_out_rd_wr_en <= execute_rd_wr_en && !w_exec_store && !(w_exec_load && w_misaligned);
        r_load_mis     <= w_exec_load && w_misaligned;
        r_store_mis    <= w_exec_store && w_misaligned;
      end
      if (w_in_access) begin
        if (writeback_flush) r_flushed <= 1'b1;
        // A flushed access still completes its handshake; only the retirement is discarded.
        if (dmem_ack) begin
          r_req          <= 1'b0;
          r_flushed      <= 1'b0;
          r_clk_en       <= !w_drop;
          r_out_rd_wr_en <= r_rd_wr_en && r_opcode[OPC_LOAD] && !w_drop;
          if (r_opcode[OPC_LOAD]) r_data_load <= w_load_data;
        end
      end else begin
        r_flushed <= 1'b0;
      end
    end
  end

  assign dmem_req     = r_req;
  assign dmem_we      = r_req && r_opcode[OPC_STORE];
  assign dmem_addr    = r_req ? {r_y[DMEM_ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata   = (r_req && r_opcode[OPC_STORE]) ? w_wdata : '0;
  assign dmem_byte_en = r_req ? w_byte_en : '0;

  assign memory_clk_en           = r_clk_en;
  assign memory_opcode_type      = r_opcode;
  assign memory_funct3           = r_funct3;
  assign memory_data_load        = r_data_load;
  assign memory_rd_wr_en         = r_out_rd_wr_en;
  assign memory_rd               = r_rd;
  assign memory_rd_wr_data       = r_y;
  assign memory_pc               = r_pc;
  assign memory_load_misaligned  = r_load_mis;
  assign memory_store_misaligned = r_store_mis;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: loads, stores, misalignment, flush and reset-during-access.
module tb_memory_access;
  import mem_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    execute_clk_en;
  logic [OPCODE_WIDTH-1:0] execute_opcode_type;
  logic [2:0]              execute_funct3;
  logic [31:0]             execute_y;
  logic [31:0]             execute_rs2_data;
  logic                    execute_rd_wr_en;
  logic [4:0]              execute_rd;
  logic [31:0]             execute_pc;
  logic                    writeback_flush;
  logic                    dmem_req;
  logic                    dmem_we;
  logic [31:0]             dmem_addr;
  logic [31:0]             dmem_wdata;
  logic [3:0]              dmem_byte_en;
  logic                    dmem_ack;
  logic [31:0]             dmem_rdata;
  logic                    memory_clk_en;
  logic [OPCODE_WIDTH-1:0] memory_opcode_type;
  logic [2:0]              memory_funct3;
  logic [31:0]             memory_data_load;
  logic                    memory_rd_wr_en;
  logic [4:0]              memory_rd;
  logic [31:0]             memory_rd_wr_data;
  logic [31:0]             memory_pc;
  logic                    memory_load_misaligned;
  logic                    memory_store_misaligned;
  logic                    next_stall;

  int n_total = 0;
  int n_bad   = 0;

  memory_access #(.DMEM_ADDR_W(32)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .execute_clk_en          (execute_clk_en),
    .execute_opcode_type     (execute_opcode_type),
    .execute_funct3          (execute_funct3),
    .execute_y               (execute_y),
    .execute_rs2_data        (execute_rs2_data),
    .execute_rd_wr_en        (execute_rd_wr_en),
    .execute_rd              (execute_rd),
    .execute_pc              (execute_pc),
    .writeback_flush         (writeback_flush),
    .dmem_req                (dmem_req),
    .dmem_we                 (dmem_we),
    .dmem_addr               (dmem_addr),
    .dmem_wdata              (dmem_wdata),
    .dmem_byte_en            (dmem_byte_en),
    .dmem_ack                (dmem_ack),
    .dmem_rdata              (dmem_rdata),
    .memory_clk_en           (memory_clk_en),
    .memory_opcode_type      (memory_opcode_type),
    .memory_funct3           (memory_funct3),
    .memory_data_load        (memory_data_load),
    .memory_rd_wr_en         (memory_rd_wr_en),
    .memory_rd               (memory_rd),
    .memory_rd_wr_data       (memory_rd_wr_data),
    .memory_pc               (memory_pc),
    .memory_load_misaligned  (memory_load_misaligned),
    .memory_store_misaligned (memory_store_misaligned),
    .next_stall              (next_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OPCODE_WIDTH-1:0] onehot(input int idx);
    logic [OPCODE_WIDTH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic issue(input int opc, input logic [2:0] f3, input logic [31:0] y,
                       input logic [31:0] rs2, input logic rd_wr_en, input logic [4:0] rd,
                       input logic [31:0] pc);
    execute_clk_en      = 1'b1;
    execute_opcode_type = onehot(opc);
    execute_funct3      = f3;
    execute_y           = y;
    execute_rs2_data    = rs2;
    execute_rd_wr_en    = rd_wr_en;
    execute_rd          = rd;
    execute_pc          = pc;
  endtask

  int stall_cycles;

  initial begin
    rst_n = 1'b0;
    execute_clk_en = 1'b0;
    execute_opcode_type = '0;
    execute_funct3 = '0;
    execute_y = '0;
    execute_rs2_data = '0;
    execute_rd_wr_en = 1'b0;
    execute_rd = '0;
    execute_pc = '0;
    writeback_flush = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    repeat (3) step();
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_clk_en", {31'd0, memory_clk_en}, 32'd0);
    chk("rst_stall", {31'd0, next_stall}, 32'd0);
    chk("rst_pc", memory_pc, 32'd0);
    chk("rst_byte_en", {28'd0, dmem_byte_en}, 32'd0);
    rst_n = 1'b1;
    step();

    // LB 0x1003, ack in first ACCESS cycle
    issue(OPC_LOAD, FUNCT3_B, 32'h0000_1003, 32'd0, 1'b1, 5'd3, 32'h0000_0100);
    step();
    execute_clk_en = 1'b0;
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_1000);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_stall", {31'd0, next_stall}, 32'd1);
    chk("lb_clk_en_early", {31'd0, memory_clk_en}, 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80FF_1234;
    step();
    dmem_ack = 1'b0;
    chk("lb_clk_en", {31'd0, memory_clk_en}, 32'd1);
    chk("lb_data", memory_data_load, 32'hFFFF_FF80);
    chk("lb_rd_wr_en", {31'd0, memory_rd_wr_en}, 32'd1);
    chk("lb_rd", {27'd0, memory_rd}, 32'd3);
    chk("lb_pc", memory_pc, 32'h0000_0100);
    chk("lb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("lb_stall_drop", {31'd0, next_stall}, 32'd0);
    step();
    chk("lb_clk_en_once", {31'd0, memory_clk_en}, 32'd0);

    // LHU 0x2002, ack after 3 wait cycles
    issue(OPC_LOAD, FUNCT3_HU, 32'h0000_2002, 32'd0, 1'b1, 5'd4, 32'h0000_0104);
    step();
    execute_clk_en = 1'b0;
    dmem_rdata = 32'hBEEF_0000;
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (next_stall) stall_cycles++;
      chk("lhu_req_hold", {31'd0, dmem_req}, 32'd1);
      chk("lhu_addr_hold", dmem_addr, 32'h0000_2000);
      chk("lhu_no_clk_en", {31'd0, memory_clk_en}, 32'd0);
      if (i == 3) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    chk("lhu_stall_cycles", stall_cycles, 32'd4);
    chk("lhu_clk_en", {31'd0, memory_clk_en}, 32'd1);
    chk("lhu_data", memory_data_load, 32'h0000_BEEF);
    chk("lhu_stall_end", {31'd0, next_stall}, 32'd0);

    // SB 0x3001
    issue(OPC_STORE, FUNCT3_B, 32'h0000_3001, 32'h0000_00AB, 1'b1, 5'd7, 32'h0000_0108);
    step();
    execute_clk_en = 1'b0;
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_byte_en", {28'd0, dmem_byte_en}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h0000_3000);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sb_clk_en", {31'd0, memory_clk_en}, 32'd1);
    chk("sb_rd_wr_en", {31'd0, memory_rd_wr_en}, 32'd0);

    // Misaligned LW 0x4002
    issue(OPC_LOAD, FUNCT3_W, 32'h0000_4002, 32'd0, 1'b1, 5'd8, 32'h0000_010C);
    step();
    execute_clk_en = 1'b0;
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_clk_en", {31'd0, memory_clk_en}, 32'd1);
    chk("lw_mis_flag", {31'd0, memory_load_misaligned}, 32'd1);
    chk("lw_mis_st_flag", {31'd0, memory_store_misaligned}, 32'd0);
    chk("lw_mis_rd_wr_en", {31'd0, memory_rd_wr_en}, 32'd0);
    chk("lw_mis_stall", {31'd0, next_stall}, 32'd0);
    step();
    chk("lw_mis_pulse", {31'd0, memory_load_misaligned}, 32'd0);

    // Misaligned SH 0x7001
    issue(OPC_STORE, FUNCT3_H, 32'h0000_7001, 32'h0000_1234, 1'b0, 5'd0, 32'h0000_0110);
    step();
    execute_clk_en = 1'b0;
    chk("sh_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("sh_mis_flag", {31'd0, memory_store_misaligned}, 32'd1);
    chk("sh_mis_clk_en", {31'd0, memory_clk_en}, 32'd1);

    // ADD retires, then SW flushed while in ACCESS
    issue(OPC_OP, 3'b000, 32'h0000_0055, 32'd0, 1'b1, 5'd5, 32'h0000_0200);
    step();
    chk("add_clk_en", {31'd0, memory_clk_en}, 32'd1);
    chk("add_data", memory_rd_wr_data, 32'h0000_0055);
    chk("add_rd", {27'd0, memory_rd}, 32'd5);
    chk("add_rd_wr_en", {31'd0, memory_rd_wr_en}, 32'd1);
    issue(OPC_STORE, FUNCT3_W, 32'h0000_5000, 32'h1234_5678, 1'b0, 5'd0, 32'h0000_0204);
    step();
    execute_clk_en = 1'b0;
    writeback_flush = 1'b1;
    chk("sw_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_byte_en", {28'd0, dmem_byte_en}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'h1234_5678);
    chk("sw_no_clk_en", {31'd0, memory_clk_en}, 32'd0);
    step();
    writeback_flush = 1'b0;
    chk("sw_flush_req_hold", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sw_flush_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("sw_flush_no_clk_en", {31'd0, memory_clk_en}, 32'd0);
    issue(OPC_OP, 3'b000, 32'h0000_0077, 32'd0, 1'b1, 5'd6, 32'h0000_0208);
    step();
    execute_clk_en = 1'b0;
    chk("after_flush_clk_en", {31'd0, memory_clk_en}, 32'd1);
    chk("after_flush_data", memory_rd_wr_data, 32'h0000_0077);

    // Flush in IDLE blocks capture
    issue(OPC_OP, 3'b000, 32'h0000_0099, 32'd0, 1'b1, 5'd9, 32'h0000_020C);
    writeback_flush = 1'b1;
    step();
    execute_clk_en = 1'b0;
    writeback_flush = 1'b0;
    chk("idle_flush_clk_en", {31'd0, memory_clk_en}, 32'd0);
    chk("idle_flush_nocap", memory_rd_wr_data, 32'h0000_0077);

    // Ack coincident with flush discards the load
    issue(OPC_LOAD, FUNCT3_W, 32'h0000_8000, 32'd0, 1'b1, 5'd10, 32'h0000_0300);
    step();
    execute_clk_en = 1'b0;
    dmem_ack = 1'b1;
    writeback_flush = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_ack = 1'b0;
    writeback_flush = 1'b0;
    chk("ackflush_clk_en", {31'd0, memory_clk_en}, 32'd0);
    chk("ackflush_req", {31'd0, dmem_req}, 32'd0);

    // Reset during ACCESS, late ack ignored
    issue(OPC_LOAD, FUNCT3_W, 32'h0000_6000, 32'd0, 1'b1, 5'd11, 32'h0000_0400);
    step();
    execute_clk_en = 1'b0;
    chk("rstacc_req_pre", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rstacc_req", {31'd0, dmem_req}, 32'd0);
    chk("rstacc_stall", {31'd0, next_stall}, 32'd0);
    chk("rstacc_pc", memory_pc, 32'd0);
    chk("rstacc_addr", dmem_addr, 32'd0);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("rstacc_late_ack", {31'd0, memory_clk_en}, 32'd0);
    step();
    chk("rstacc_late_ack2", {31'd0, memory_clk_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline MEM stage between execute and writeback; drives the data-memory req/ack port for loads and stores.
- Aligns and extends load data; detects misaligned accesses.
- Registers everything writeback consumes (memory_* signals) and issues exactly one memory_clk_en pulse per retired instruction.
- Stalls upstream while a data-memory access is outstanding.

Parameters:
- DMEM_ADDR_W, 32, data-memory byte address width (upper bits zero-padded to 32 where required).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- execute_clk_en  in  1  valid instruction presented by execute this cycle
- execute_opcode_type  in  `OPCODE_WIDTH  one-hot opcode type (`LOAD, `STORE, `SYSTEM, ...)
- execute_funct3  in  3  access size/sign
- execute_y  in  32  ALU result: effective address for ld/st, rd data otherwise
- execute_rs2_data  in  32  store data
- execute_rd_wr_en  in  1  rd write enable
- execute_rd  in  5  rd address
- execute_pc  in  32  pc of instruction
- writeback_flush  in  1  flush from writeback (trap/mret)
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DMEM_ADDR_W  word-aligned address (addr[1:0]=0)
- dmem_wdata  out  32  lane-replicated store data
- dmem_byte_en  out  4  byte lanes
- dmem_ack  in  1  access complete; dmem_rdata valid same cycle
- dmem_rdata  in  32  read word
- memory_clk_en  out  1  one-cycle valid pulse to writeback
- memory_opcode_type  out  `OPCODE_WIDTH  registered opcode type
- memory_funct3  out  3  registered funct3
- memory_data_load  out  32  extended load data
- memory_rd_wr_en  out  1  rd write enable (0 if flushed or misaligned)
- memory_rd  out  5  rd address
- memory_rd_wr_data  out  32  registered execute_y
- memory_pc  out  32  registered pc
- memory_load_misaligned  out  1  pulses with memory_clk_en
- memory_store_misaligned  out  1  pulses with memory_clk_en
- next_stall  out  1  hold execute and earlier stages

Behaviour:
- Reset: all outputs 0, FSM IDLE, flushed bit 0. Reset mid-access drops dmem_req immediately; a late ack is ignored.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On execute_clk_en & !writeback_flush: capture all execute_* into stage registers.
  - Aligned load/store: go to ACCESS. dmem_req is registered and rises the next cycle.
  - Any other instruction: memory_clk_en=1 next cycle (latency 1).
- ACCESS:
  - dmem_req=1; addr, we, wdata and byte_en held stable until ack.
  - next_stall=1 combinationally for the whole of ACCESS.
  - memory_clk_en=0.
  - On dmem_ack: latch the extended load into memory_data_load, dmem_req=0 next cycle, memory_clk_en=1 next cycle, return to IDLE.
  - Minimum load/store latency is 2 cycles (ack in the first ACCESS cycle).
- Alignment:
  - LH/LHU/SH: misaligned when addr[0]=1.
  - LW/SW: misaligned when addr[1:0]≠0.
  - Misaligned: no dmem_req; matching misaligned flag=1 and memory_rd_wr_en=0 on the memory_clk_en cycle; latency 1.
- Store data:
  - SB: wdata={4{rs2[7:0]}}, byte_en=1<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, byte_en=4'b0011<<addr[1:0].
  - SW: wdata=rs2, byte_en=4'b1111.
- Load extension: lane selected by addr[1:0].
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: passthrough.
  - Undefined funct3: treat as LW.
- Stores: memory_rd_wr_en=0 regardless of the input.
- Flush:
  - writeback_flush in IDLE: input not captured; any memory_clk_en due next cycle is suppressed.
  - writeback_flush in ACCESS: the access is not aborted; set the flushed bit, complete the handshake (stores do write), discard the result. No memory_clk_en; flushed bit cleared in IDLE.
  - Simultaneous dmem_ack & writeback_flush: same as flush in ACCESS.
- memory_clk_en: never high two consecutive cycles for one instruction.
- While next_stall=1: execute_clk_en is ignored.

Decomposition:
- Reuse `LOAD/`STORE/`SYSTEM and `OPCODE_WIDTH from rv32i_header.vh.
- Add funct3 constants (FUNCT3_B/H/W/BU/HU) to decode_header.vh.
- FSM state enum goes in a shared mem_pkg.
- One combinational sub-module, load_store_align: takes addr[1:0], funct3, rs2, rdata; produces wdata, byte_en, extended load, misaligned flag.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234, ack in first ACCESS cycle -> dmem_addr=0x1000, memory_data_load=0xFFFF_FF80, memory_clk_en 2 cycles after capture, next_stall high 1 cycle.
- LHU, addr 0x2002, rdata 0xBEEF_0000, ack delayed 3 cycles -> memory_data_load=0x0000_BEEF, next_stall high 4 cycles, dmem_req stable throughout.
- SB, addr 0x3001, rs2=0x0000_00AB -> dmem_we=1, byte_en=4'b0010, wdata=0xABAB_ABAB, memory_rd_wr_en=0.
- LW, addr 0x4002 -> no dmem_req, memory_load_misaligned=1 with memory_clk_en next cycle, memory_rd_wr_en=0.
- ADD, y=0x55, rd=5, then writeback_flush during a following SW in ACCESS -> ADD retires with memory_rd_wr_data=0x55; SW completes handshake, no memory_clk_en.
- rst_n=0 during ACCESS -> dmem_req=0 and all outputs 0 next cycle; a subsequent ack produces no memory_clk_en.
